// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO and its read-side stream adapter.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 32;
    localparam int unsigned SKID_DEPTH = 3;

    typedef logic [1:0] buf_idx_t;
    typedef logic [1:0] buf_occ_t;

    // Circular increment over SKID_DEPTH entries.
    function automatic buf_idx_t idx_next(input buf_idx_t idx);
        return (idx == buf_idx_t'(SKID_DEPTH - 1)) ? buf_idx_t'(0) : idx + buf_idx_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Three-entry circular output buffer with occupancy tracking; clear empties it in one cycle.
module fifo_rd_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output buf_occ_t         occ
);

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    buf_idx_t         wr_idx_q;
    buf_idx_t         rd_idx_q;
    buf_occ_t         occ_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            occ_q    <= '0;
        end else if (clear) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            occ_q    <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_idx_q] <= wr_data;
                wr_idx_q        <= idx_next(wr_idx_q);
            end
            if (pop) begin
                rd_idx_q <= idx_next(rd_idx_q);
            end
            if (wr_en && !pop) begin
                occ_q <= occ_q + buf_occ_t'(1);
            end else if (!wr_en && pop) begin
                occ_q <= occ_q - buf_occ_t'(1);
            end
        end
    end

    assign head = mem_q[rd_idx_q];
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO pop interface to valid/ready stream adapter with flush and transfer/drop statistics.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = FIFO_WIDTH,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_rd_data,
    input  logic                 fifo_empty,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] xfer_count,
    output logic [7:0]           drop_count
);

    logic                 inflight_q;
    logic                 discard_q;
    logic [CNT_WIDTH-1:0] xfer_q;
    logic [7:0]           drop_q;
    logic [7:0]           drop_d;
    buf_occ_t             occ;
    logic                 handshake;
    logic                 buf_wr;
    logic [2:0]           occ_pending;
    logic [2:0]           drop_inc;
    logic [8:0]           drop_sum;

    // Issue decision uses only registered occupancy, never out_ready.
    assign occ_pending = {1'b0, occ} + {2'b0, inflight_q};
    assign fifo_rd_en  = !reset && !flush && !fifo_empty && (occ_pending < 3'(SKID_DEPTH));
    assign out_valid   = (occ != '0);
    assign handshake   = out_valid && out_ready;
    assign buf_wr      = inflight_q && !discard_q && !flush;

    fifo_rd_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clock   (clock),
        .reset   (reset),
        .clear   (flush),
        .wr_en   (buf_wr),
        .wr_data (fifo_rd_data),
        .pop     (handshake),
        .head    (out_data),
        .occ     (occ)
    );

    // A flush drops every buffered word plus the one returning this cycle, except the one
    // leaving through a same-cycle handshake.
    always_comb begin
        drop_inc = {2'b0, inflight_q && discard_q};
        if (flush) begin
            drop_inc = occ_pending - 3'(handshake);
        end
        drop_sum = {1'b0, drop_q} + {6'b0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            xfer_q     <= '0;
            drop_q     <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            discard_q  <= flush && inflight_q;
            xfer_q     <= xfer_q + CNT_WIDTH'(handshake);
            drop_q     <= drop_d;
        end
    end

    assign xfer_count = xfer_q;
    assign drop_count = drop_q;

endmodule
